// File: rtl/frame_reduce_pkg.sv
`default_nettype none
// ============================================================================
// Module  : frame_reduce_pkg
// Brief   : Shared types and constants for the frame reduction accumulator.
// Revision: 1.0
// ============================================================================
package frame_reduce_pkg;

    typedef enum logic [0:0] {
        ACCUM = 1'b0,
        FULL  = 1'b1
    } state_e;

    localparam logic C_AND_INIT = 1'b1;

    // col_xor is WIDTH-dependent, so it lives beside this struct in the top.
    typedef struct packed {
        logic and_b;
        logic nand_b;
        logic or_b;
        logic nor_b;
        logic xor_b;
        logic xnor_b;
        logic perr;
    } res_flags_t;

endpackage : frame_reduce_pkg
`default_nettype wire

// File: rtl/frame_reduce_accum_beat_reduce.sv
`default_nettype none
// ============================================================================
// Module  : beat_reduce
// Brief   : Combinational per-word AND / OR / XOR reduction of one input beat.
// Revision: 1.0
// ============================================================================
module beat_reduce #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] data_i,
    output logic             and_o,
    output logic             or_o,
    output logic             xor_o
);

    assign and_o = &data_i;
    assign or_o  = |data_i;
    assign xor_o = ^data_i;

endmodule : beat_reduce
`default_nettype wire

// File: rtl/frame_reduce_accum.sv
`default_nettype none
// ============================================================================
// Module  : frame_reduce_accum
// Brief   : Groups FRAME_LEN input beats into a frame and emits registered
//           AND/NAND/OR/NOR/XOR/XNOR flags plus a column XOR per frame.
//           Optional macro PARITY_CHECK_EN enables the frame parity compare.
// Revision: 1.0
// ============================================================================
module frame_reduce_accum
    import frame_reduce_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter int FRAME_LEN = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_par,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_and,
    output logic             out_nand,
    output logic             out_or,
    output logic             out_nor,
    output logic             out_xor,
    output logic             out_xnor,
    output logic [WIDTH-1:0] out_col_xor,
    output logic             parity_err
);

    localparam int              CNT_W      = $clog2(FRAME_LEN + 1);
    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(FRAME_LEN - 1);
    localparam logic [CNT_W-1:0] C_CNT_ONE  = CNT_W'(1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
    logic             acc_and_q, acc_and_d;
    logic             acc_or_q, acc_or_d;
    logic [WIDTH-1:0] acc_col_q, acc_col_d;
    res_flags_t       res_q, res_d;
    logic [WIDTH-1:0] res_col_q, res_col_d;

    logic w_red_and, w_red_or, w_red_xor;
    logic w_accept, w_last, w_out_valid, w_frame_xor, w_perr;

    beat_reduce #(
        .WIDTH (WIDTH)
    ) u_beat_reduce (
        .data_i (in_data),
        .and_o  (w_red_and),
        .or_o   (w_red_or),
        .xor_o  (w_red_xor)
    );

    assign w_out_valid = (state_q == FULL);
    assign in_ready    = !rst && (!w_out_valid || out_ready);
    assign w_accept    = in_valid && in_ready;
    assign w_last      = w_accept && (beat_cnt_q == C_CNT_LAST);
    assign w_frame_xor = (^acc_col_q) ^ w_red_xor;

`ifdef PARITY_CHECK_EN
    assign w_perr = (w_frame_xor != in_par);
`else
    logic w_unused_par;
    assign w_unused_par = in_par;
    assign w_perr       = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        beat_cnt_d = beat_cnt_q;
        acc_and_d  = acc_and_q;
        acc_or_d   = acc_or_q;
        acc_col_d  = acc_col_q;
        res_d      = res_q;
        res_col_d  = res_col_q;

        if (w_accept) begin
            if (w_last) begin
                res_d.and_b  = acc_and_q & w_red_and;
                res_d.nand_b = ~(acc_and_q & w_red_and);
                res_d.or_b   = acc_or_q | w_red_or;
                res_d.nor_b  = ~(acc_or_q | w_red_or);
                res_d.xor_b  = w_frame_xor;
                res_d.xnor_b = ~w_frame_xor;
                res_d.perr   = w_perr;
                res_col_d    = acc_col_q ^ in_data;
                acc_and_d    = C_AND_INIT;
                acc_or_d     = 1'b0;
                acc_col_d    = '0;
                beat_cnt_d   = '0;
            end else begin
                acc_and_d  = acc_and_q & w_red_and;
                acc_or_d   = acc_or_q | w_red_or;
                acc_col_d  = acc_col_q ^ in_data;
                beat_cnt_d = beat_cnt_q + C_CNT_ONE;
            end
        end

        // A new last beat while FULL implies a drain in the same cycle.
        case (state_q)
            ACCUM: if (w_last) state_d = FULL;
            FULL: begin
                if (w_last)         state_d = FULL;
                else if (out_ready) state_d = ACCUM;
            end
            default: state_d = ACCUM;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ACCUM;
            beat_cnt_q <= '0;
            acc_and_q  <= C_AND_INIT;
            acc_or_q   <= 1'b0;
            acc_col_q  <= '0;
            res_q      <= '0;
            res_col_q  <= '0;
        end else begin
            state_q    <= state_d;
            beat_cnt_q <= beat_cnt_d;
            acc_and_q  <= acc_and_d;
            acc_or_q   <= acc_or_d;
            acc_col_q  <= acc_col_d;
            res_q      <= res_d;
            res_col_q  <= res_col_d;
        end
    end

    assign out_valid   = w_out_valid;
    assign out_and     = res_q.and_b;
    assign out_nand    = res_q.nand_b;
    assign out_or      = res_q.or_b;
    assign out_nor     = res_q.nor_b;
    assign out_xor     = res_q.xor_b;
    assign out_xnor    = res_q.xnor_b;
    assign out_col_xor = res_col_q;
    assign parity_err  = res_q.perr;

endmodule : frame_reduce_accum
`default_nettype wire

// File: tb/tb_frame_reduce_accum.sv
`default_nettype none
// ============================================================================
// Module  : tb_frame_reduce_accum
// Brief   : Scoreboard bench; instance A uses FRAME_LEN=2, instance B FRAME_LEN=1.
// Revision: 1.0
// ============================================================================
module tb_frame_reduce_accum;

    localparam int W = 4;
`ifdef PARITY_CHECK_EN
    localparam bit PCHK = 1'b1;
`else
    localparam bit PCHK = 1'b0;
`endif

    typedef logic [W+3:0] exp_t;   // {and, or, xor, col[W-1:0], perr}

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [W-1:0] a_data, a_col;
    logic a_valid, a_ready, a_par, a_ovalid, a_oready;
    logic a_and, a_nand, a_or, a_nor, a_xor, a_xnor, a_perr;

    logic [W-1:0] b_data, b_col;
    logic b_valid, b_ready, b_par, b_ovalid, b_oready;
    logic b_and, b_nand, b_or, b_nor, b_xor, b_xnor, b_perr;

    frame_reduce_accum #(.WIDTH(W), .FRAME_LEN(2)) dut_a (
        .clk(clk), .rst(rst), .in_data(a_data), .in_valid(a_valid), .in_ready(a_ready),
        .in_par(a_par), .out_valid(a_ovalid), .out_ready(a_oready),
        .out_and(a_and), .out_nand(a_nand), .out_or(a_or), .out_nor(a_nor),
        .out_xor(a_xor), .out_xnor(a_xnor), .out_col_xor(a_col), .parity_err(a_perr)
    );

    frame_reduce_accum #(.WIDTH(W), .FRAME_LEN(1)) dut_b (
        .clk(clk), .rst(rst), .in_data(b_data), .in_valid(b_valid), .in_ready(b_ready),
        .in_par(b_par), .out_valid(b_ovalid), .out_ready(b_oready),
        .out_and(b_and), .out_nand(b_nand), .out_or(b_or), .out_nor(b_nor),
        .out_xor(b_xor), .out_xnor(b_xnor), .out_col_xor(b_col), .parity_err(b_perr)
    );

    int   errors = 0;
    int   checks = 0;
    exp_t qa[$];
    exp_t qb[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic exp_t mk(input bit a, input bit o, input bit x,
                                input logic [W-1:0] c, input bit par);
        return {a, o, x, c, PCHK & (x != par)};
    endfunction

    always @(negedge clk) begin
        if (!rst && a_ovalid && a_oready) begin
            exp_t e;
            logic [2:0] ne;
            if (qa.size() == 0) begin
                chk("a_unexpected_result", 32'd1, 32'd0);
            end else begin
                e  = qa.pop_front();
                ne = ~e[W+3:W+1];
                chk("a_result", {a_and, a_or, a_xor, a_col, a_perr}, e);
                chk("a_complements", {a_nand, a_nor, a_xnor}, ne);
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && b_ovalid && b_oready) begin
            exp_t e;
            logic [2:0] ne;
            if (qb.size() == 0) begin
                chk("b_unexpected_result", 32'd1, 32'd0);
            end else begin
                e  = qb.pop_front();
                ne = ~e[W+3:W+1];
                chk("b_result", {b_and, b_or, b_xor, b_col, b_perr}, e);
                chk("b_complements", {b_nand, b_nor, b_xnor}, ne);
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the beat is accepted.
    task automatic send_a(input logic [W-1:0] d, input logic p);
        int n;
        bit ok;
        n = 0;
        ok = 1'b0;
        a_data  = d;
        a_par   = p;
        a_valid = 1'b1;
        do begin
            @(negedge clk);
            ok = a_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!ok && n < 20);
        if (!ok) chk("a_send_timeout", 32'd0, 32'd1);
        a_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [W-1:0] bv [4];
        bit           ba [4];
        bit           bo [4];
        bit           bx [4];
        bit           bp [4];
        int           n;

        bv = '{4'b1010, 4'b1111, 4'b0000, 4'b0111};
        ba = '{1'b0, 1'b1, 1'b0, 1'b0};
        bo = '{1'b1, 1'b1, 1'b0, 1'b1};
        bx = '{1'b0, 1'b0, 1'b0, 1'b1};
        bp = '{1'b0, 1'b1, 1'b0, 1'b1};

        rst = 1'b1;
        a_data = '0; a_valid = 1'b0; a_par = 1'b0; a_oready = 1'b1;
        b_data = '0; b_valid = 1'b0; b_par = 1'b0; b_oready = 1'b1;
        #2;
        chk("rst_a_in_ready", a_ready, 32'd0);
        chk("rst_a_out_valid", a_ovalid, 32'd0);
        chk("rst_a_outputs", {a_and, a_nand, a_or, a_nor, a_xor, a_xnor, a_col, a_perr}, 32'd0);
        chk("rst_b_out_valid", b_ovalid, 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;

        // Mixed bits, all ones, then the mixed frame again with opposite parity.
        qa.push_back(mk(1'b0, 1'b1, 1'b1, 4'b1110, 1'b1));
        send_a(4'b0110, 1'b1);
        send_a(4'b1000, 1'b1);
        qa.push_back(mk(1'b1, 1'b1, 1'b0, 4'b0000, 1'b0));
        send_a(4'b1111, 1'b0);
        send_a(4'b1111, 1'b0);
        qa.push_back(mk(1'b0, 1'b1, 1'b1, 4'b1110, 1'b0));
        send_a(4'b0110, 1'b0);
        send_a(4'b1000, 1'b0);
        repeat (2) @(posedge clk);
        #1;

        // Backpressure: result held, input stalled, then single-cycle drain.
        a_oready = 1'b0;
        qa.push_back(mk(1'b0, 1'b1, 1'b0, 4'b0011, 1'b0));
        send_a(4'b0001, 1'b0);
        send_a(4'b0010, 1'b0);
        a_data = 4'b0100; a_par = 1'b1; a_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_out_valid", a_ovalid, 32'd1);
            chk("stall_in_ready", a_ready, 32'd0);
            chk("stall_result", {a_and, a_or, a_xor, a_col}, {3'b010, 4'b0011});
            @(posedge clk);
            #1;
        end
        a_oready = 1'b1;
        @(negedge clk);
        chk("drain_in_ready", a_ready, 32'd1);
        @(posedge clk);
        #1 a_valid = 1'b0;
        @(negedge clk);
        chk("drained_out_valid", a_ovalid, 32'd0);
        chk("held_after_drain", a_col, 32'b0011);
        @(posedge clk);
        #1;
        qa.push_back(mk(1'b0, 1'b1, 1'b1, 4'b1000, 1'b1));
        send_a(4'b1100, 1'b1);

        // Reset mid-frame discards the partial 1111 beat.
        send_a(4'b1111, 1'b0);
        #3 rst = 1'b1;
        #1;
        chk("midrst_in_ready", a_ready, 32'd0);
        chk("midrst_out_valid", a_ovalid, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        chk("midrst_outputs", {a_and, a_nand, a_or, a_nor, a_xor, a_xnor, a_col, a_perr}, 32'd0);
        qa.push_back(mk(1'b0, 1'b0, 1'b0, 4'b0000, 1'b0));
        send_a(4'b0000, 1'b0);
        send_a(4'b0000, 1'b0);

        // FRAME_LEN=1 streaming: one result per cycle with no bubble.
        b_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            qb.push_back(mk(ba[i], bo[i], bx[i], bv[i], bp[i]));
            b_data = bv[i];
            b_par  = bp[i];
            @(negedge clk);
            chk("b_in_ready", b_ready, 32'd1);
            if (i > 0) chk("b_continuous_valid", b_ovalid, 32'd1);
            @(posedge clk);
            #1;
        end
        b_valid = 1'b0;
        @(negedge clk);
        chk("b_last_valid", b_ovalid, 32'd1);

        n = 0;
        while ((qa.size() != 0 || qb.size() != 0) && n < 20) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk("a_queue_drained", qa.size(), 32'd0);
        chk("b_queue_drained", qb.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_frame_reduce_accum
`default_nettype wire
